// File: rtl/toggle_rx.sv
// rtl/toggle_rx.sv - 2-phase toggle receiver with valid/ready handshake, saturating event count and overrun flag.
// Optional two-flop input synchronizer enabled by defining TOGGLE_RX_SYNC_EN.
module toggle_rx #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             t_in,
    input  logic             ready,
    input  logic             clr_ovr,
    output logic             valid,
    output logic             ack_tgl,
    output logic [CNT_W-1:0] evt_cnt,
    output logic             overrun
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t state;
    logic   s;
    logic   p;
    logic   toggle;
    logic   drop;
    logic   accept;

`ifdef TOGGLE_RX_SYNC_EN
    logic s1;
    logic s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= t_in;
            s2 <= s1;
        end
    end

    assign s = s2;
`else
    assign s = t_in;
`endif

    assign toggle = s ^ p;
    assign accept = (state == PEND) && ready;
    // A new edge while the previous event is still unaccepted cannot be queued.
    assign drop   = (state == PEND) && !ready && toggle;
    assign valid  = (state == PEND);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            p       <= 1'b0;
            ack_tgl <= 1'b0;
            evt_cnt <= '0;
            overrun <= 1'b0;
        end else begin
            p <= s;

            case (state)
                IDLE: begin
                    if (toggle) begin
                        state <= PEND;
                    end
                end
                PEND: begin
                    if (accept) begin
                        ack_tgl <= ~ack_tgl;
                        if (evt_cnt != {CNT_W{1'b1}}) begin
                            evt_cnt <= evt_cnt + 1'b1;
                        end
                        // An edge arriving on the accept cycle becomes the next pending event.
                        state <= toggle ? PEND : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_toggle_rx.sv
// tb/tb_toggle_rx.sv - directed self-checking bench for toggle_rx.
module tb_toggle_rx;

`ifdef TOGGLE_RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       t_in;
    logic       ready;
    logic       clr_ovr;
    logic       valid;
    logic       ack_tgl;
    logic [7:0] evt_cnt;
    logic       overrun;
    logic       valid2;
    logic       ack_tgl2;
    logic [1:0] evt_cnt2;
    logic       overrun2;

    int errors = 0;
    int checks = 0;

    toggle_rx #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .t_in(t_in), .ready(ready), .clr_ovr(clr_ovr),
        .valid(valid), .ack_tgl(ack_tgl), .evt_cnt(evt_cnt), .overrun(overrun)
    );

    toggle_rx #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .t_in(t_in), .ready(ready), .clr_ovr(clr_ovr),
        .valid(valid2), .ack_tgl(ack_tgl2), .evt_cnt(evt_cnt2), .overrun(overrun2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst     = 1'b1;
        t_in    = 1'b0;
        ready   = 1'b1;
        clr_ovr = 1'b0;
        step(2);
        check("rst_valid", valid, 0);
        check("rst_ack", ack_tgl, 0);
        check("rst_cnt", evt_cnt, 0);
        check("rst_ovr", overrun, 0);
        rst = 1'b0;
        step(2);

        // Single event with ready held high
        t_in = 1'b1;
        step(LAT);
        check("lat_not_yet", valid, 0);
        step(1);
        check("single_valid", valid, 1);
        check("single_ack_pre", ack_tgl, 0);
        step(1);
        check("single_valid_drop", valid, 0);
        check("single_ack", ack_tgl, 1);
        check("single_cnt", evt_cnt, 1);

        // ready ignored in IDLE
        step(3);
        check("idle_ack", ack_tgl, 1);
        check("idle_cnt", evt_cnt, 1);

        // Held event, accepted after 5 cycles
        ready = 1'b0;
        t_in  = 1'b0;
        step(LAT + 1);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", valid, 1);
            check("hold_ack", ack_tgl, 1);
            step(1);
        end
        ready = 1'b1;
        step(1);
        check("hold_ack_acc", ack_tgl, 0);
        check("hold_cnt", evt_cnt, 2);
        check("hold_valid_off", valid, 0);
        check("hold_ovr", overrun, 0);

        // Overrun: two toggles 4 cycles apart while ready=0
        ready = 1'b0;
        t_in  = 1'b1;
        step(4);
        t_in = 1'b0;
        step(LAT + 1);
        check("ovr_set", overrun, 1);
        check("ovr_cnt_hold", evt_cnt, 2);
        check("ovr_valid", valid, 1);
        ready = 1'b1;
        step(1);
        check("ovr_cnt_acc", evt_cnt, 3);
        check("ovr_valid_off", valid, 0);
        check("ovr_sticky", overrun, 1);
        ready   = 1'b0;
        clr_ovr = 1'b1;
        step(1);
        clr_ovr = 1'b0;
        check("ovr_clr", overrun, 0);

        // Set beats clear on the same edge
        t_in = 1'b1;
        step(LAT + 2);
        t_in = 1'b0;
        step(LAT);
        clr_ovr = 1'b1;
        step(1);
        clr_ovr = 1'b0;
        check("ovr_set_wins", overrun, 1);
        clr_ovr = 1'b1;
        step(1);
        clr_ovr = 1'b0;
        check("ovr_clr2", overrun, 0);
        ready = 1'b1;
        step(1);
        check("sw_cnt", evt_cnt, 4);
        check("sw_valid_off", valid, 0);

        // Back-to-back: accept edge coincides with a new toggle
        ready = 1'b0;
        t_in  = 1'b1;
        step(LAT + 2);
        t_in = 1'b0;
        step(LAT);
        ready = 1'b1;
        step(1);
        check("b2b_valid", valid, 1);
        check("b2b_cnt", evt_cnt, 5);
        check("b2b_ovr", overrun, 0);
        step(1);
        check("b2b_valid_off", valid, 0);
        check("b2b_cnt2", evt_cnt, 6);
        check("b2b_ack", ack_tgl, 0);

        // Saturation with CNT_W=2
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(1);
        for (int i = 0; i < 5; i++) begin
            t_in = ~t_in;
            step(LAT + 2);
            check("sat_cnt", evt_cnt2, (i + 1 > 3) ? 3 : i + 1);
            check("sat_ack", ack_tgl2, (i + 1) % 2);
        end
        check("sat_wide_cnt", evt_cnt, 5);

        // Asynchronous reset during PEND
        ready = 1'b0;
        t_in  = 1'b0;
        step(LAT + 2);
        t_in = 1'b1;
        step(LAT + 1);
        check("pre_rst_valid", valid, 1);
        check("pre_rst_ovr", overrun, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", valid, 0);
        check("arst_ack", ack_tgl, 0);
        check("arst_cnt", evt_cnt, 0);
        check("arst_ovr", overrun, 0);
        step(2);
        rst = 1'b0;
        step(LAT + 1);
        check("rel_valid", valid, 1);
        check("rel_ack", ack_tgl, 0);
        ready = 1'b1;
        step(1);
        check("rel_ack_acc", ack_tgl, 1);
        check("rel_cnt", evt_cnt, 1);
        step(3);
        check("rel_single", evt_cnt, 1);
        check("rel_idle", valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/toggle_rx.md
TOGGLE_RX -- requirements
Module: toggle_rx

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, the width of the accepted-event counter.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, the reset; asynchronous and active-high.
REQ-004 The block SHALL have port t_in, input, 1 bit, the 2-phase toggle line; each level change is one event, as produced by a T flip-flop with t=1 for one cycle per event.
REQ-005 The block SHALL have port ready, input, 1 bit, the downstream consumer's acceptance of the pending event.
REQ-006 The block SHALL have port clr_ovr, input, 1 bit, a synchronous clear for the overrun flag.
REQ-007 The block SHALL have port valid, output, 1 bit, which is high while an event is pending.
REQ-008 The block SHALL have port ack_tgl, output, 1 bit, the 2-phase acknowledge; it toggles once per accepted event.
REQ-009 The block SHALL have port evt_cnt, output, CNT_W bits, the saturating count of accepted events.
REQ-010 The block SHALL have port overrun, output, 1 bit, a sticky flag for events dropped while pending.

Function
REQ-011 The block SHALL hold a sampled level s (the synchronizer output) and a previous level p, and SHALL define toggle = s XOR p; p SHALL load s on every clock edge.
REQ-012 The state machine SHALL have two states, IDLE (valid=0) and PEND (valid=1), and SHALL drive valid directly from the state register.
REQ-013 In IDLE with toggle=1, the block SHALL move to PEND on that edge.
REQ-014 In PEND, the edge with ready=1 is the accept edge; on it ack_tgl SHALL invert and evt_cnt SHALL increment.
REQ-015 evt_cnt SHALL saturate at 2^CNT_W-1 with no wrap; accepts at saturation SHALL still toggle ack_tgl.
REQ-016 On an accept edge with toggle=1 in the same cycle, the block SHALL stay in PEND (back-to-back event) with no overrun; with toggle=0 it SHALL return to IDLE.
REQ-017 In PEND with ready=0 and toggle=1, the block SHALL drop the new event, not count it, set overrun, and remain in PEND.
REQ-018 overrun SHALL clear on an edge where clr_ovr=1, unless a new overrun occurs on that same edge, in which case set SHALL win.
REQ-019 ready SHALL be ignored in IDLE; it SHALL NOT toggle ack_tgl or change evt_cnt.
REQ-020 Latency with synchronizer: t_in changes before edge E0, valid SHALL be high after edge E2; without synchronizer, valid SHALL be high after E0.

Reset
REQ-021 While rst=1, the block SHALL force valid=0, ack_tgl=0, evt_cnt=0 and overrun=0, SHALL clear the synchronizer stages and p, and SHALL be in IDLE.
REQ-022 A reset during PEND SHALL discard the pending event without toggling ack_tgl.
REQ-023 If t_in=1 when rst deasserts, the block SHALL detect one event (since p resets to 0); senders SHALL reset their toggle line with the same rst.

Configuration
REQ-024 Macro TOGGLE_RX_SYNC_EN defined: t_in SHALL pass through two flops (s1, s2) before forming s, for t_in driven from an unrelated clock.
REQ-025 Macro TOGGLE_RX_SYNC_EN undefined: s SHALL be t_in used directly, for t_in synchronous to clk; all other behaviour is identical except REQ-020 latency.

Verification
REQ-026 Reset with t_in=0, then one toggle of t_in with ready held 1 -> valid pulses for 1 cycle (after E2 with sync), ack_tgl becomes 1, evt_cnt=1.
REQ-027 Hold ready=0, one toggle, wait 5 cycles, then ready=1 -> valid high for the entire wait, ack_tgl toggles only on the accept edge, evt_cnt=1, overrun=0.
REQ-028 ready=0, two toggles 4 cycles apart -> overrun=1, evt_cnt stays 0 until accept, then 1; clr_ovr pulse -> overrun=0.
REQ-029 CNT_W=2, 5 accepted events -> evt_cnt=3 after events 3, 4 and 5, and ack_tgl shows 5 inversions (ends at 1).
REQ-030 Assert rst during PEND -> valid, ack_tgl, evt_cnt and overrun are all 0 immediately, with no clock edge needed; release with t_in=1 -> one event detected.
REQ-031 Build both with and without TOGGLE_RX_SYNC_EN -> detection latency differs by exactly 2 cycles, and counts and flags are identical.
